// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed byte frame,
// packs big-endian 32-bit words, writes them out and releases the CPU on a good checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [7:0]          len_hi_r;
    logic [15:0]         len_r;
    logic [1:0]          byte_cnt_r;
    logic [ADDR_W-1:0]   word_idx_r;
    logic [23:0]         word_r;
    logic [7:0]          csum_r;

    logic                accept_s;
    logic                word_done_s;
    logic                last_word_s;
    logic                len_bad_s;
    logic [15:0]         len_s;
    logic                ready_s;
    logic                done_s;
    logic                error_s;
    logic                hold_s;

    assign accept_s    = in_valid & in_ready;
    assign word_done_s = accept_s && (state_r == DATA) && (byte_cnt_r == 2'd3);
    assign len_s       = {len_hi_r, in_data};
    assign len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS);
    // Length check bounds word_idx_r to ADDR_W bits, so a zero-extended compare suffices.
    assign last_word_s = (16'(word_idx_r) == (len_r - 16'd1));

    // State register plus registered per-state outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            in_ready <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            in_ready <= ready_s;
            done     <= done_s;
            error    <= error_s;
            cpu_hold <= hold_s;
        end
    end

    // Next-state logic; every transition out of a receiving state needs a handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) state_next_s = HDR_HI;
                else       state_next_s = state_r;
            end
            HDR_HI: begin
                if (accept_s) state_next_s = HDR_LO;
                else          state_next_s = state_r;
            end
            HDR_LO: begin
                if (accept_s) state_next_s = len_bad_s ? ERR : DATA;
                else          state_next_s = state_r;
            end
            DATA: begin
                if (word_done_s && last_word_s) state_next_s = CSUM;
                else                            state_next_s = state_r;
            end
            CSUM: begin
                if (accept_s) state_next_s = (in_data == csum_r) ? DONE : ERR;
                else          state_next_s = state_r;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs track state_r exactly.
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        error_s = 1'b0;
        hold_s  = 1'b1;
        case (state_next_s)
            HDR_HI, HDR_LO, DATA, CSUM: ready_s = 1'b1;
            DONE: begin
                done_s = 1'b1;
                hold_s = 1'b0;
            end
            ERR:     error_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Datapath: header latch, word packing, checksum accumulation and the write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0000_0000;
            len_hi_r   <= 8'h00;
            len_r      <= 16'h0000;
            byte_cnt_r <= 2'd0;
            word_idx_r <= '0;
            word_r     <= 24'h00_0000;
            csum_r     <= 8'h00;
        end else begin
            mem_we <= word_done_s;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_cnt_r <= 2'd0;
                        word_idx_r <= '0;
                        csum_r     <= 8'h00;
                        mem_addr   <= '0;
                    end
                end
                HDR_HI: begin
                    if (accept_s) len_hi_r <= in_data;
                end
                HDR_LO: begin
                    if (accept_s) len_r <= len_s;
                end
                DATA: begin
                    if (accept_s) begin
                        word_r     <= {word_r[15:0], in_data};
                        csum_r     <= csum_fold(csum_r, in_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            mem_addr   <= word_idx_r;
                            mem_wdata  <= {word_r, in_data};
                            word_idx_r <= word_idx_r + ADDR_W'(1'b1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
